uart_receiver: RTL and testbench

UART receive path, 8N1, LSB first; the counterpart of the team's UART transmitter on the same serial link.
- Oversamples the asynchronous Rx line using a shared baud-rate clock enable running at OVERSAMPLE × baud.
- Rejects glitches on the start bit and samples each data bit at mid-bit.
- Presents each received byte with a sticky ready flag, plus framing-error and overrun status.

---
 rtl/uart_receiver.sv | 105 ++++++++++
 tb/tb_uart_receiver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, oversampled by a shared clken at OVERSAMPLE x baud.
// Start-bit glitch rejection, mid-bit data sampling, sticky rdy / frame_err / overrun.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       Rx,
    input  logic       clken,
    input  logic       rdy_clr,
    output logic [7:0] data,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       Rx_busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_M1 = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] ONE    = SW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_prev;
    logic [SW-1:0] sample;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign rx_s    = sync[1];
    assign Rx_busy = (state != IDLE);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= IDLE;
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            sample    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync <= {sync[0], Rx};
            // Clears first so that a set on the same edge overrides them.
            if (rdy_clr) begin
                rdy       <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (clken) begin
                rx_prev <= rx_s;
                case (state)
                    IDLE: begin
                        if (!rx_s && rx_prev) begin
                            state  <= START;
                            sample <= '0;
                        end
                    end
                    START: begin
                        if (sample != MID_M1) begin
                            sample <= sample + ONE;
                        end else if (!rx_s) begin
                            state   <= DATA;
                            sample  <= '0;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DATA: begin
                        if (sample != LAST) begin
                            sample <= sample + ONE;
                        end else begin
                            shift[bit_idx] <= rx_s;
                            sample         <= '0;
                            if (bit_idx == 3'd7) state <= STOP;
                            else                 bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    STOP: begin
                        if (sample != LAST) begin
                            sample <= sample + ONE;
                        end else begin
                            sample <= '0;
                            state  <= IDLE;
                            if (rx_s) begin
                                data <= shift;
                                rdy  <= 1'b1;
                                if (rdy) overrun <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expected bytes are queued by the stimulus,
// a monitor pops and checks them (with stop-sample latency) whenever a byte is presented.
module tb_uart_receiver;
    localparam int BIT_CLK = 432;
    localparam int CK_DIV  = 27;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       Rx;
    logic       clken;
    logic       rdy_clr;
    logic [7:0] data;
    logic       rdy, frame_err, overrun, Rx_busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    logic clr_req     = 1'b0;
    logic collide_arm = 1'b0;
    int   lat         = 0;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .Rx       (Rx),
        .clken    (clken),
        .rdy_clr  (rdy_clr),
        .data     (data),
        .rdy      (rdy),
        .frame_err(frame_err),
        .overrun  (overrun),
        .Rx_busy  (Rx_busy)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // clken divider and rdy_clr driver, all on the falling edge
    initial begin
        int div;
        div     = 0;
        clken   = 1'b0;
        rdy_clr = 1'b0;
        forever begin
            @(negedge clk_50m);
            div     = (div == CK_DIV - 1) ? 0 : div + 1;
            clken   = (div == CK_DIV - 1);
            rdy_clr = clr_req || (collide_arm && clken && Rx_busy && lat == 151);
            clr_req = 1'b0;
        end
    end

    // Monitor: a byte is presented when rdy rises or data changes while rdy is high.
    initial begin
        logic       rdy_d, busy_d;
        logic [7:0] data_d, e;
        rdy_d = 0; busy_d = 0; data_d = 0;
        forever begin
            @(posedge clk_50m);
            #1;
            if (rst) begin
                rdy_d = 0; busy_d = 0; data_d = 0; lat = 0;
            end else begin
                if (Rx_busy && !busy_d) lat = 0;
                else if (clken)         lat++;
                if (rdy && (!rdy_d || data != data_d)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", 32'(data), 32'(e));
                        chk("rx_latency_ticks", 32'(lat), 32'd152);
                    end
                end
                rdy_d = rdy; data_d = data; busy_d = Rx_busy;
            end
        end
    end

    task automatic drive(input logic v, input int n);
        Rx = v;
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(b[i], BIT_CLK);
        if (stop_low_bits > 0) drive(1'b0, stop_low_bits * BIT_CLK);
        else                   drive(1'b1, BIT_CLK);
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        repeat (2) @(negedge clk_50m);
    endtask

    initial begin
        rst = 1'b1;
        Rx  = 1'b1;
        repeat (4) @(negedge clk_50m);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_rdy", 32'(rdy), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_busy", 32'(Rx_busy), 0);
        rst = 1'b0;
        drive(1'b1, 2 * BIT_CLK);

        // single frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0);
        drive(1'b1, BIT_CLK);
        chk("a5_rdy", 32'(rdy), 1);
        chk("a5_frame_err", 32'(frame_err), 0);
        chk("a5_busy", 32'(Rx_busy), 0);
        pulse_clr();
        chk("clr_rdy", 32'(rdy), 0);

        // back-to-back, no rdy_clr between
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        drive(1'b1, BIT_CLK);
        chk("b2b_data", 32'(data), 32'hFF);
        chk("b2b_rdy", 32'(rdy), 1);
        chk("b2b_overrun", 32'(overrun), 1);
        pulse_clr();
        chk("b2b_clr_rdy", 32'(rdy), 0);
        chk("b2b_clr_overrun", 32'(overrun), 0);

        // start glitch of 3 clken ticks
        drive(1'b0, 3 * CK_DIV);
        drive(1'b1, 300);
        chk("glitch_busy", 32'(Rx_busy), 0);
        chk("glitch_rdy", 32'(rdy), 0);
        chk("glitch_frame_err", 32'(frame_err), 0);
        chk("glitch_overrun", 32'(overrun), 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 0);
        drive(1'b1, BIT_CLK);
        chk("3c_rdy", 32'(rdy), 1);
        pulse_clr();

        // framing error, line held low past the stop bit
        send_frame(8'h55, 2);
        chk("fe_frame_err", 32'(frame_err), 1);
        chk("fe_rdy", 32'(rdy), 0);
        chk("fe_data_held", 32'(data), 32'h3C);
        chk("fe_no_false_start", 32'(Rx_busy), 0);
        drive(1'b1, 2 * BIT_CLK);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 0);
        drive(1'b1, BIT_CLK);
        chk("81_rdy", 32'(rdy), 1);
        pulse_clr();
        chk("81_clr_frame_err", 32'(frame_err), 0);

        // rdy_clr on the stop-sample edge
        collide_arm = 1'b1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 0);
        drive(1'b1, BIT_CLK);
        collide_arm = 1'b0;
        chk("collide_rdy", 32'(rdy), 1);
        chk("collide_data", 32'(data), 32'h7E);

        // reset during data bit 4
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(8'hC3 >> i, BIT_CLK);
        drive(1'b0, BIT_CLK / 2);
        rst = 1'b1;
        Rx  = 1'b1;
        @(negedge clk_50m);
        chk("mid_rst_data", 32'(data), 32'h00);
        chk("mid_rst_rdy", 32'(rdy), 0);
        chk("mid_rst_frame_err", 32'(frame_err), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_busy", 32'(Rx_busy), 0);
        rst = 1'b0;
        drive(1'b1, 2 * BIT_CLK);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 0);
        drive(1'b1, BIT_CLK);
        chk("12_rdy", 32'(rdy), 1);
        chk("12_data", 32'(data), 32'h12);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
